dmem_arbiter: RTL

- Shares the single-port data memory between the pipeline MEM stage (CPU port) and an external loader/debug port (EXT port).
- Sits between the EX/MEM register outputs and the data memory.
- Produces cpu_stall, which freezes the PC, F/D, D/E and E/M registers while a CPU access is pending.
- CPU has priority. A starvation counter forces an EXT grant after MAX_WAIT lost cycles. A read watchdog aborts hung reads.

---
 rtl/dmem_arb_pkg.sv | 13 +
 rtl/dmem_arb_starve_cnt.sv | 33 +++
 rtl/dmem_arbiter.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizing for the data-memory arbiter.
// CPU MEM stage and EXT loader/debug port compete for the single-port data memory.
package dmem_arb_pkg;

    localparam int AW_DEF         = 32;
    localparam int DW_DEF         = 32;
    localparam int MAX_WAIT_DEF   = 8;
    localparam int RD_TIMEOUT_DEF = 16;

    typedef enum logic {IDLE, RD_WAIT} state_t;
    typedef enum logic {OWN_CPU, OWN_EXT} owner_t;

endpackage

// File: rtl/dmem_arb_starve_cnt.sv
// Saturating count of consecutive arbitration cycles the EXT port has lost.
// Clear wins over increment.
module dmem_arb_starve_cnt #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic n_rst,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int CW = $clog2(MAX + 1);
    localparam logic [CW-1:0] MAX_C = CW'(MAX);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i)
            cnt_d = '0;
        else if (inc_i && (cnt_q != MAX_C))
            cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign sat_o = (cnt_q == MAX_C);

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the single-port data memory between the CPU MEM stage and the EXT port.
// CPU has priority; a starvation counter forces EXT through, a watchdog aborts hung reads.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int AW         = AW_DEF,
    parameter int DW         = DW_DEF,
    parameter int MAX_WAIT   = MAX_WAIT_DEF,
    parameter int RD_TIMEOUT = RD_TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          cpu_re,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          ext_req,
    input  logic          ext_we,
    input  logic [AW-1:0] ext_addr,
    input  logic [DW-1:0] ext_wdata,
    output logic          ext_gnt,
    output logic          ext_rvalid,
    output logic [DW-1:0] ext_rdata,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic          mem_ready,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          mem_err
);

    localparam int WDW = (RD_TIMEOUT > 1) ? $clog2(RD_TIMEOUT) : 1;
    localparam logic [WDW-1:0] WD_LAST = WDW'(RD_TIMEOUT - 1);

    state_t         state_q, state_d;
    owner_t         owner_q, owner_d;
    logic [WDW-1:0] wd_q, wd_d;

    logic cpu_any, sel_ext, req_v, req_we, starve_sat;
    logic rd_done, rd_tmo, cpu_done;

    assign cpu_any = cpu_re | cpu_we;
    assign sel_ext = ext_req & (starve_sat | ~cpu_any);
    assign req_v   = sel_ext | cpu_any;
    // Both cpu_re and cpu_we high resolves to a store.
    assign req_we  = sel_ext ? ext_we : cpu_we;
    assign rd_done = (state_q == RD_WAIT) & mem_rvalid;
    assign rd_tmo  = (state_q == RD_WAIT) & ~mem_rvalid & (wd_q == WD_LAST);

    dmem_arb_starve_cnt #(.MAX(MAX_WAIT)) u_starve (
        .clk   (clk),
        .n_rst (n_rst),
        .inc_i ((state_q == IDLE) & ext_req & ~ext_gnt),
        .clr_i (~ext_req | ext_gnt),
        .sat_o (starve_sat)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= IDLE;
            owner_q <= OWN_CPU;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                if (req_v && mem_ready && !req_we) begin
                    state_d = RD_WAIT;
                    owner_d = sel_ext ? OWN_EXT : OWN_CPU;
                    wd_d    = '0;
                end
            end
            RD_WAIT: begin
                wd_d = wd_q + 1'b1;
                if (rd_done || rd_tmo) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        ext_gnt    = 1'b0;
        ext_rvalid = 1'b0;
        ext_rdata  = '0;
        cpu_rdata  = '0;
        mem_err    = 1'b0;
        cpu_done   = 1'b0;
        case (state_q)
            IDLE: begin
                mem_req = req_v;
                mem_we  = req_v & req_we;
                if (sel_ext) begin
                    mem_addr  = ext_addr;
                    mem_wdata = ext_wdata;
                end else if (cpu_any) begin
                    mem_addr  = cpu_addr;
                    mem_wdata = cpu_wdata;
                end
                ext_gnt  = sel_ext & mem_ready;
                cpu_done = ~sel_ext & cpu_we & mem_ready;
            end
            RD_WAIT: begin
                mem_err = rd_tmo;
                // A timed-out read still completes, with zero data.
                if (owner_q == OWN_CPU) begin
                    cpu_done  = rd_done | rd_tmo;
                    cpu_rdata = rd_done ? mem_rdata : '0;
                end else begin
                    ext_rvalid = rd_done | rd_tmo;
                    ext_rdata  = rd_done ? mem_rdata : '0;
                end
            end
            default: ;
        endcase
    end

    assign cpu_stall = cpu_any & ~cpu_done;

endmodule
